display_arbiter: RTL and testbench

- Shares the single 4-digit 7-segment display among NUM_REQ requesters (debug counters, status codes, error codes).
- Round-robin rotation with a fixed dwell time per requester; urgent requests preempt the rotation.
- Output value/dot_pattern drive the decimal display driver directly; values above 9999 are clamped.

---
 rtl/display_arbiter.sv | 138 +++++++++++++
 tb/tb_display_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// Round-robin / urgent-preempt arbiter sharing one 4-digit 7-segment display
// among NUM_REQ requesters; registered value is clamped to 0..9999.
module display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 200000000
) (
  input  logic                 sysclk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   urgent,
  input  logic [NUM_REQ*15-1:0] values,
  input  logic [NUM_REQ*4-1:0] dots,
  output logic [NUM_REQ-1:0]   grant,
  output logic [14:0]          value,
  output logic [3:0]           dot_pattern,
  output logic                 blank,
  output logic                 switched
);

  // state    | meaning
  // ST_IDLE  | no owner, display blanked
  // ST_SHOW  | round-robin owner, dwell counter running
  // ST_URGENT| lowest-index effective urgent requester owns the display

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD    = CW'(HOLD_CYCLES - 1);
  localparam logic [14:0]   MAX_VAL = 15'd9999;

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_URGENT} state_t;

  state_t           state, nxt_state;
  logic [IW-1:0]    ptr, nxt_ptr;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic [NUM_REQ-1:0] eff_urg, nxt_grant;
  logic             any_urg, rr_found;
  logic [IW-1:0]    urg_idx, rr_idx, cand;
  logic [14:0]      sel_val, nxt_value;
  logic [3:0]       nxt_dot;

  // ptr doubles as the current owner while not idle, so every search starts at ptr+1
  always_comb begin : arb_comb
    eff_urg = urgent & req;
    any_urg = |eff_urg;

    urg_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (eff_urg[k]) urg_idx = IW'(k);
    end

    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end

    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_cnt   = cnt;
    case (state)
      ST_IDLE: begin
        if (any_urg) begin
          nxt_state = ST_URGENT;
          nxt_ptr   = urg_idx;
        end else if (rr_found) begin
          nxt_state = ST_SHOW;
          nxt_ptr   = rr_idx;
          nxt_cnt   = LOAD;
        end
      end
      ST_SHOW: begin
        if (any_urg) begin
          nxt_state = ST_URGENT;
          nxt_ptr   = urg_idx;
        end else if (!req[ptr] || cnt == '0) begin
          if (rr_found) begin
            nxt_ptr = rr_idx;
            nxt_cnt = LOAD;
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      ST_URGENT: begin
        if (any_urg) begin
          nxt_ptr = urg_idx;
        end else if (rr_found) begin
          nxt_state = ST_SHOW;
          nxt_ptr   = rr_idx;
          nxt_cnt   = LOAD;
        end else begin
          nxt_state = ST_IDLE;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase

    nxt_grant = '0;
    nxt_value = '0;
    nxt_dot   = '0;
    sel_val   = values[15*int'(nxt_ptr) +: 15];
    if (nxt_state != ST_IDLE) begin
      nxt_grant[nxt_ptr] = 1'b1;
      nxt_value = (sel_val > MAX_VAL) ? MAX_VAL : sel_val;
      nxt_dot   = dots[4*int'(nxt_ptr) +: 4];
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      cnt         <= '0;
      grant       <= '0;
      value       <= '0;
      dot_pattern <= '0;
      blank       <= 1'b1;
      switched    <= 1'b0;
    end else begin
      state       <= nxt_state;
      ptr         <= nxt_ptr;
      cnt         <= nxt_cnt;
      grant       <= nxt_grant;
      value       <= nxt_value;
      dot_pattern <= nxt_dot;
      blank       <= (nxt_state == ST_IDLE);
      switched    <= (nxt_grant != grant);
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized + directed bench for display_arbiter against a behavioural model.
module tb_display_arbiter;

  localparam int NR   = 4;
  localparam int HOLD = 4;

  logic          sysclk = 1'b0;
  logic          reset_n;
  logic [NR-1:0] req, urgent;
  logic [NR*15-1:0] values;
  logic [NR*4-1:0]  dots;
  logic [NR-1:0] grant;
  logic [14:0]   value;
  logic [3:0]    dot_pattern;
  logic          blank, switched;

  logic [14:0] v [NR];
  logic [3:0]  d [NR];

  assign values = {v[3], v[2], v[1], v[0]};
  assign dots   = {d[3], d[2], d[1], d[0]};

  always #5 sysclk = ~sysclk;

  display_arbiter #(.NUM_REQ(NR), .HOLD_CYCLES(HOLD)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .req(req), .urgent(urgent),
    .values(values), .dots(dots), .grant(grant), .value(value),
    .dot_pattern(dot_pattern), .blank(blank), .switched(switched)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=idle 1=rotating 2=urgent; owner is also the last granted index.
  int          m_mode, m_owner, m_age;
  logic [3:0]  e_grant, e_prev;
  logic [14:0] e_value;
  logic [3:0]  e_dot;
  logic        e_blank, e_sw;

  function automatic int next_rr(input int from, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++)
      if (r[(from + k) % NR]) return (from + k) % NR;
    return -1;
  endfunction

  function automatic int lowest(input logic [NR-1:0] m);
    for (int k = 0; k < NR; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = NR - 1; m_age = 0;
    e_grant = '0; e_prev = '0; e_value = '0; e_dot = '0; e_blank = 1'b1; e_sw = 1'b0;
  endtask

  task automatic model_step();
    int ue, nr;
    ue = lowest(urgent & req);
    nr = next_rr(m_owner, req);
    if (ue >= 0) begin
      m_mode = 2; m_owner = ue;
    end else if (m_mode == 1 && req[m_owner] && m_age < HOLD - 1) begin
      m_age++;
    end else if (nr >= 0) begin
      m_mode = 1; m_owner = nr; m_age = 0;
    end else begin
      m_mode = 0;
    end
    e_grant = '0;
    if (m_mode != 0) e_grant[m_owner] = 1'b1;
    e_value = (m_mode == 0) ? 15'd0 : ((v[m_owner] > 15'd9999) ? 15'd9999 : v[m_owner]);
    e_dot   = (m_mode == 0) ? 4'd0 : d[m_owner];
    e_blank = (m_mode == 0);
    e_sw    = (e_grant != e_prev);
    e_prev  = e_grant;
  endtask

  task automatic step();
    model_step();
    @(posedge sysclk);
    #1;
    check("grant", 32'(grant), 32'(e_grant));
    check("value", 32'(value), 32'(e_value));
    check("dot", 32'(dot_pattern), 32'(e_dot));
    check("blank", 32'(blank), 32'(e_blank));
    check("switched", 32'(switched), 32'(e_sw));
  endtask

  function automatic logic [14:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 15'd9999;
      1: return 15'd10000;
      2: return 15'd32767;
      3: return 15'd9998;
      default: return 15'($urandom);
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; req = '0; urgent = '0;
    for (int i = 0; i < NR; i++) begin v[i] = '0; d[i] = 4'(i + 1); end
    model_reset();
    repeat (3) @(posedge sysclk);
    #2 reset_n = 1'b1;
    #1;

    repeat (10) step();

    // rotation between r0 and r2
    v[0] = 15'd12; v[2] = 15'd345; req = 4'b0101;
    step();
    check("tp_first_grant", 32'(grant), 32'h1);
    check("tp_first_value", 32'(value), 32'd12);
    check("tp_first_pulse", 32'(switched), 32'h1);
    repeat (4) step();
    check("tp_rot_r2", 32'(grant), 32'h4);
    check("tp_rot_val", 32'(value), 32'd345);
    repeat (4) step();
    check("tp_rot_r0", 32'(grant), 32'h1);

    // single requester, clamped value, no pulse on dwell expiry
    v[1] = 15'd20000; req = 4'b0010;
    step();
    check("tp_clamp", 32'(value), 32'd9999);
    repeat (9) step();
    check("tp_hold_grant", 32'(grant), 32'h2);

    // urgent preemption and return
    req = 4'b0001; step();
    req = 4'b1011; urgent = 4'b1000; step();
    check("tp_urg3", 32'(grant), 32'h8);
    urgent = 4'b1010; step();
    check("tp_urg1", 32'(grant), 32'h2);
    urgent = 4'b0000; step();
    check("tp_urg_ret", 32'(grant), 32'h8);
    step();

    // owner drops mid-dwell
    req = 4'b0100; step();
    req = 4'b0101; step();
    req = 4'b0001; step();
    check("tp_drop", 32'(grant), 32'h1);
    req = 4'b0000; step();
    check("tp_idle_blank", 32'(blank), 32'h1);

    // async reset mid-dwell
    req = 4'b0101; step(); step();
    #3 reset_n = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_blank", 32'(blank), 32'h1);
    check("rst_value", 32'(value), 32'h0);
    check("rst_sw", 32'(switched), 32'h0);
    model_reset();
    @(negedge sysclk);
    reset_n = 1'b1;
    req = 4'b1000;
    step();
    check("rst_regrant", 32'(grant), 32'h8);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      if ($urandom_range(0, 9) == 0) urgent = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, NR - 1);
        v[i] = rand_val();
        d[i] = 4'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
